// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first.
// A three-state controller (IDLE/RUN/DONE) captures operands on start,
// ripples the borrow through WIDTH RUN cycles and then pulses done for one
// cycle. The result is assembled by shifting each difference bit into diff
// from the MSB end, so diff is only meaningful once done is seen.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             bit_diff,
  output logic             bit_valid
);

  // Wide enough to hold WIDTH itself, so the count cannot wrap mid-operation.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             b_out;

  // Full-subtractor difference bit.
  function automatic logic sub_diff(input logic ai, input logic bi, input logic bi_n);
    return ai ^ bi ^ bi_n;
  endfunction

  // Full-subtractor borrow-out.
  function automatic logic sub_borrow(input logic ai, input logic bi, input logic bi_n);
    return (~ai & bi) | (~(ai ^ bi) & bi_n);
  endfunction

  // Current bit pair from the operand LSBs and the stored borrow.
  always_comb begin
    d_bit = sub_diff(a_sr[0], b_sr[0], bin);
    b_out = sub_borrow(a_sr[0], b_sr[0], bin);
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign bit_valid = (state == RUN);
  assign bit_diff  = (state == RUN) & d_bit;

  // Controller and serial datapath; reset clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff   <= {d_bit, diff[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bin    <= b_out;
          borrow <= b_out;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: drivers push expected results as
// they issue requests, monitors pop and compare whenever done is presented.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8, bd8, bv8;
  logic [7:0] diff8;
  logic       busy4, done4, borrow4, bd4, bv4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [8:0] sb8[$];   // {borrow, diff}
  int         lat8[$];  // cycle count at which done must be seen
  logic       bits8[$]; // expected serial bits
  logic [4:0] sb4[$];

  int   vcount = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
    .bit_diff(bd8), .bit_valid(bv8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
    .bit_diff(bd4), .bit_valid(bv4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (bv8) begin
      vcount++;
      if (bits8.size() > 0) chk("bit_diff", {31'd0, bd8}, {31'd0, bits8.pop_front()});
    end
    if (done8) begin
      chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      chk("bit_valid_count", vcount, 8);
      vcount = 0;
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb8.pop_front();
        chk("diff8", {24'd0, diff8}, {24'd0, e[7:0]});
        chk("borrow8", {31'd0, borrow8}, {31'd0, e[8]});
        chk("latency8", cyc, lat8.pop_front());
      end
    end
    prev_done = done8;
    if (rst) vcount = 0;
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    logic [4:0] e;
    if (done4) begin
      if (sb4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: got done=1 expected no pending result");
      end else begin
        e = sb4.pop_front();
        chk("diff4", {28'd0, diff4}, {28'd0, e[3:0]});
        chk("borrow4", {31'd0, borrow4}, {31'd0, e[4]});
      end
    end
  end

  // One complete operation on the 8-bit instance; called at a negedge in IDLE.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    sb8.push_back({eb, ed});
    lat8.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    repeat (9) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, busy8}, 32'd0);
    chk({nm, "_done"}, {31'd0, done8}, 32'd0);
    chk({nm, "_bit_valid"}, {31'd0, bv8}, 32'd0);
    chk({nm, "_diff"}, {24'd0, diff8}, 32'd0);
    chk({nm, "_borrow"}, {31'd0, borrow8}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // 0x5A - 0x3C = 0x1E, serial bits 0,1,1,1,1,0,0,0
    bits8 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_op(8'h5A, 8'h3C, 8'h1E, 1'b0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1);
    // Result holds through IDLE.
    repeat (4) @(negedge clk);
    chk("hold_diff", {24'd0, diff8}, 32'hFF);
    chk("hold_borrow", {31'd0, borrow8}, 32'd1);
    do_op(8'hA5, 8'hA5, 8'h00, 1'b0);

    // Re-pulsed start during RUN is ignored.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    sb8.push_back({1'b0, 8'h0F});
    lat8.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_in_run", {31'd0, busy8}, 32'd1);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    repeat (7) @(negedge clk);

    // Reset in RUN cycle 4 aborts with no done, then a start right after.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("abort");
    do_op(8'h80, 8'h7F, 8'h01, 1'b0);

    // Start held high: an operation every 10 cycles.
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h30;
    for (int i = 0; i < 3; i++) begin
      sb8.push_back({1'b1, 8'hF0});
      lat8.push_back(cyc + 9 + 10 * i);
    end
    repeat (30) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] av, bv;
      av = 4'(i >> 4);
      bv = 4'(i);
      start4 = 1'b1; a4 = av; b4 = bv;
      sb4.push_back({(av < bv), 4'(av - bv)});
      @(negedge clk);
      start4 = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (8) @(negedge clk);

    chk("sb8_drained", sb8.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, unsigned; captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, unsigned; captured on an accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  final borrow-out; 1 iff a < b unsigned.
REQ-011 SHALL have port bit_diff  output  1  serial difference bit of the current RUN cycle, LSB first.
REQ-012 SHALL have port bit_valid  output  1  qualifies bit_diff; high for exactly WIDTH cycles per operation.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at edge k -> capture a, b into shift registers, clear internal borrow, clear bit counter, go to RUN.
REQ-015 RUN: at each of edges k+1 .. k+WIDTH, process one bit pair (ai, bi, bin) from the registered LSBs.
- d = ai ^ bi ^ bin
- bout = (~ai & bi) | (~(ai ^ bi) & bin)
REQ-016 RUN: each processed bit SHALL shift d into the diff register from the MSB end, shift both operand registers right, and store bout as the next bin.
REQ-017 bit_diff and bit_valid SHALL be combinational from RUN state and registered LSBs; bit i is presented in the cycle before edge k+1+i.
REQ-018 After edge k+WIDTH the FSM SHALL be in DONE with done=1, busy=0, diff fully assembled, borrow = final bout.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE; start during DONE SHALL be ignored.
REQ-020 Latency from the start-sampling edge to the edge making done high SHALL be exactly WIDTH cycles; throughput is one operation per WIDTH+2 cycles.
REQ-021 start, a, and b SHALL be ignored while busy=1; captured operands SHALL be unaffected by input changes after capture.
REQ-022 diff and borrow SHALL hold their last result through IDLE until the next operation's first RUN edge.
- During RUN, diff SHALL show partial shifted contents that are not meaningful.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.
REQ-024 An X or 0 on start in IDLE SHALL keep the FSM in IDLE with all outputs unchanged.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, busy=0, done=0, bit_valid=0, diff=0, borrow=0, and clear the counter, borrow, and operand registers.
REQ-026 rst SHALL take priority over start and over an in-progress RUN.
- An aborted operation SHALL produce no done pulse.
REQ-027 After rst deasserts, a start in the first IDLE cycle SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, start 1 cycle -> done exactly 8 cycles later; diff=0x1E, borrow=0; bit_diff sequence LSB-first 0,1,1,1,1,0,0,0.
REQ-029 a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xA5, b=0xA5 -> diff=0x00, borrow=0.
REQ-030 start pulsed with a=0x10, b=0x01, then start re-pulsed with a=0xFF, b=0x00 at RUN cycle 3 -> second request ignored; diff=0x0F, borrow=0, single done pulse.
REQ-031 rst asserted at RUN cycle 4 -> next cycle IDLE with all outputs 0 and no done; a new start afterward with a=0x80, b=0x7F -> diff=0x01, borrow=0.
REQ-032 start held high continuously -> operations complete every WIDTH+2 cycles; done never high in two consecutive cycles; bit_valid high for exactly 8 cycles per operation.
REQ-033 Exhaustive check at WIDTH=4: all 256 (a,b) pairs -> diff == (a-b) mod 16 and borrow == (a<b).
